z80_io_frontend: RTL and testbench
==================================

// Module: z80_io_frontend
// PURPOSE
//  Front end for the Z80 I/O bus, sitting directly upstream of zube.
//  Synchronises the asynchronous Z80 strobes, address and data into clk.
//  Filters glitches and classifies each cycle as an I/O read or I/O write.
//  Emits single-cycle read/write pulses with a stable latched address and data,
//  plus a read-active level that gates the external transceiver. INTACK cycles
//  (z80_m1 low) are ignored.
// PARAMETERS
//  SYNC_STAGES     2     flops per synchroniser chain (min 2)
//  FILTER_CYCLES   3     consecutive synced cycles a qualifier must hold before acceptance (min 1)
//  TIMEOUT_CYCLES  1023  max clks in an active cycle before forced abort (min 1)
// PORTS
//  clk                  in   1  high-speed (wishbone) clock
//  reset_b              in   1  asynchronous, active-low reset
//  z80_write_strobe_b   in   1  async, low = write strobe
//  z80_read_strobe_b    in   1  async, low = read strobe
//  z80_ioreq_b          in   1  async, low = I/O request
//  z80_m1               in   1  async, high = valid IOREQ, low = INTACK
//  z80_address_bus      in   8  async, low 8 address bits
//  z80_data_bus_in      in   8  async, incoming data
//  io_write_pulse       out  1  one clk: accepted I/O write
//  io_read_pulse        out  1  one clk: accepted I/O read
//  io_address           out  8  address latched at last pulse
//  io_write_data        out  8  data latched at last write pulse
//  io_read_active       out  1  high from read pulse until read released / timeout
//  timeout_pulse        out  1  one clk: active cycle exceeded TIMEOUT_CYCLES
//  protocol_error_pulse out  1  one clk: read and write qualified simultaneously
// BEHAVIOUR
//  Reset (async assert, sync deassert inside clk domain)
//   - all outputs 0; FSM in IDLE; counters 0.
//   - strobe sync flops load deasserted: _b inputs 1, m1 0.
//  Sync
//   - every input passes SYNC_STAGES flops.
//   - rd_q = m1_s & ~ioreq_b_s & ~rd_b_s; wr_q likewise with wr_b_s.
//  FSM states: IDLE, QUAL_RD, QUAL_WR, ACT_RD, ACT_WR, WAIT_REL
//   IDLE
//    - rd_q & wr_q -> WAIT_REL, pulse protocol_error.
//    - rd_q -> QUAL_RD, cnt=1.
//    - wr_q -> QUAL_WR, cnt=1.
//   QUAL_x
//    - qualifier low -> IDLE; glitch, no pulse.
//    - other qualifier high -> WAIT_REL + protocol_error.
//    - cnt==FILTER_CYCLES -> pulse, latch io_address (and io_write_data for a write), go ACT_x, cnt=0.
//    - else cnt++.
//   ACT_x
//    - qualifier low -> IDLE.
//    - cnt==TIMEOUT_CYCLES -> timeout_pulse, WAIT_REL.
//    - else cnt++.
//   WAIT_REL
//    - rd_q==0 & wr_q==0 -> IDLE.
//  io_read_active = (state==ACT_RD); registered, asserts with io_read_pulse.
//  Latency
//   - pulse asserts exactly SYNC_STAGES+FILTER_CYCLES clk edges after the first edge sampling asserted raw qualifiers.
//   - defaults: 5.
//  Pulse and latch behaviour
//   - at most one pulse per Z80 cycle; a strobe held any length gives one pulse.
//   - io_address / io_write_data hold until the next pulse of the same kind.
//   - a read pulse does not alter io_write_data.
//  Filter
//   - qualifier dropout of 1 synced clk during QUAL restarts qualification from IDLE.
//   - dropout in ACT ends the cycle.
//  Counters saturate; they do not wrap.
//  Reset asserted mid-cycle: immediate IDLE, outputs 0. A strobe still held at release must requalify fully.
// TESTING
//  T1 IO write addr 0x80 data 0x5A, strobe 20 clks
//     -> single io_write_pulse at edge 5; io_address=0x80, io_write_data=0x5A.
//  T2 IO read addr 0x81, strobe 12 clks
//     -> io_read_pulse at edge 5; io_read_active 1 until 2 clks after release; no write pulse.
//  T3 write strobe low for 2 clks only
//     -> no pulse.
//     Same with z80_m1=0 (INTACK), strobe held 20 clks
//     -> no pulse.
//  T4 read held 1100 clks, TIMEOUT=1023
//     -> one timeout_pulse; io_read_active falls; no new pulse until release plus a fresh strobe.
//  T5 read and write both low together
//     -> protocol_error_pulse once; no io pulses.
//  T6 reset_b low mid ACT_WR, then release with strobe still low
//     -> outputs 0 immediately; new pulse 5 clks after release.

Source files
------------

// File: rtl/z80_io_frontend.sv
// z80_io_frontend
//   Clock-domain front end for the Z80 I/O bus. The asynchronous strobes,
//   address and data are brought into clk through SYNC_STAGES-deep flop
//   chains. Each bus cycle is then classified as an I/O read or an I/O write
//   (INTACK cycles, where m1 is low, are ignored) and glitch-filtered. An
//   accepted cycle produces one single-clk pulse with a latched address
//   (and data for writes).
//
// Ports
//   clk                  in   clock
//   reset_b              in   asynchronous active-low reset
//   z80_write_strobe_b   in   async, low = write strobe
//   z80_read_strobe_b    in   async, low = read strobe
//   z80_ioreq_b          in   async, low = I/O request
//   z80_m1               in   async, high = I/O cycle, low = INTACK
//   z80_address_bus[7:0] in   async low address byte
//   z80_data_bus_in[7:0] in   async write data
//   io_write_pulse       out  one clk per accepted write
//   io_read_pulse        out  one clk per accepted read
//   io_address[7:0]      out  address latched at the last pulse
//   io_write_data[7:0]   out  data latched at the last write pulse
//   io_read_active       out  high while an accepted read is in progress
//   timeout_pulse        out  one clk when an active cycle runs too long
//   protocol_error_pulse out  one clk when read and write qualify together
module z80_io_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       z80_write_strobe_b,
    input  logic       z80_read_strobe_b,
    input  logic       z80_ioreq_b,
    input  logic       z80_m1,
    input  logic [7:0] z80_address_bus,
    input  logic [7:0] z80_data_bus_in,
    output logic       io_write_pulse,
    output logic       io_read_pulse,
    output logic [7:0] io_address,
    output logic [7:0] io_write_data,
    output logic       io_read_active,
    output logic       timeout_pulse,
    output logic       protocol_error_pulse
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > FILTER_CYCLES) ? TIMEOUT_CYCLES : FILTER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_FILT_LAST = CNT_W'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        QUAL_RD,
        QUAL_WR,
        ACT_RD,
        ACT_WR,
        WAIT_REL
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0]      r_wr_b_sync;
    logic [SYNC_STAGES-1:0]      r_rd_b_sync;
    logic [SYNC_STAGES-1:0]      r_ioreq_b_sync;
    logic [SYNC_STAGES-1:0]      r_m1_sync;
    logic [SYNC_STAGES-1:0][7:0] r_addr_sync;
    logic [SYNC_STAGES-1:0][7:0] r_data_sync;

    // Chains reset to the deasserted bus state so a strobe still held when
    // reset releases has to travel the full chain and requalify.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_b_sync    <= '1;
            r_rd_b_sync    <= '1;
            r_ioreq_b_sync <= '1;
            r_m1_sync      <= '0;
            r_addr_sync    <= '0;
            r_data_sync    <= '0;
        end else begin
            r_wr_b_sync    <= {r_wr_b_sync[SYNC_STAGES-2:0],    z80_write_strobe_b};
            r_rd_b_sync    <= {r_rd_b_sync[SYNC_STAGES-2:0],    z80_read_strobe_b};
            r_ioreq_b_sync <= {r_ioreq_b_sync[SYNC_STAGES-2:0], z80_ioreq_b};
            r_m1_sync      <= {r_m1_sync[SYNC_STAGES-2:0],      z80_m1};
            r_addr_sync    <= {r_addr_sync[SYNC_STAGES-2:0],    z80_address_bus};
            r_data_sync    <= {r_data_sync[SYNC_STAGES-2:0],    z80_data_bus_in};
        end
    end

    logic       w_rd_q;
    logic       w_wr_q;
    logic [7:0] w_addr_s;
    logic [7:0] w_data_s;

    assign w_rd_q   = r_m1_sync[SYNC_STAGES-1] & ~r_ioreq_b_sync[SYNC_STAGES-1] & ~r_rd_b_sync[SYNC_STAGES-1];
    assign w_wr_q   = r_m1_sync[SYNC_STAGES-1] & ~r_ioreq_b_sync[SYNC_STAGES-1] & ~r_wr_b_sync[SYNC_STAGES-1];
    assign w_addr_s = r_addr_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    // ----------------------------------------------------------------- FSM
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_rd_pulse, w_wr_pulse, w_timeout, w_perr;

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // The sample taken in IDLE is the first of FILTER_CYCLES qualifying
    // samples, so QUAL fires once it has seen FILTER_CYCLES-1 earlier ones.
    // This keeps the pulse at SYNC_STAGES+FILTER_CYCLES edges after the raw
    // strobe is first sampled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_pulse  = 1'b0;
        w_wr_pulse  = 1'b0;
        w_timeout   = 1'b0;
        w_perr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rd_q && w_wr_q) begin
                    w_state_nxt = WAIT_REL;
                    w_perr      = 1'b1;
                end else if (w_rd_q) begin
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = ACT_RD;
                        w_rd_pulse  = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_RD;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else if (w_wr_q) begin
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = ACT_WR;
                        w_wr_pulse  = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_WR;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            QUAL_RD: begin
                if (!w_rd_q) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_wr_q) begin
                    w_state_nxt = WAIT_REL;
                    w_cnt_nxt   = '0;
                    w_perr      = 1'b1;
                end else if (r_cnt >= C_FILT_LAST) begin
                    w_state_nxt = ACT_RD;
                    w_cnt_nxt   = '0;
                    w_rd_pulse  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            QUAL_WR: begin
                if (!w_wr_q) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_rd_q) begin
                    w_state_nxt = WAIT_REL;
                    w_cnt_nxt   = '0;
                    w_perr      = 1'b1;
                end else if (r_cnt >= C_FILT_LAST) begin
                    w_state_nxt = ACT_WR;
                    w_cnt_nxt   = '0;
                    w_wr_pulse  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ACT_RD, ACT_WR: begin
                if ((r_state == ACT_RD) ? !w_rd_q : !w_wr_q) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= C_TIMEOUT) begin
                    w_state_nxt = WAIT_REL;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            WAIT_REL: begin
                w_cnt_nxt = '0;
                if (!w_rd_q && !w_wr_q) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------- outputs
    logic       r_rd_pulse, r_wr_pulse, r_timeout, r_perr, r_rd_active;
    logic [7:0] r_addr, r_wdata;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rd_pulse  <= 1'b0;
            r_wr_pulse  <= 1'b0;
            r_timeout   <= 1'b0;
            r_perr      <= 1'b0;
            r_rd_active <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd_pulse  <= w_rd_pulse;
            r_wr_pulse  <= w_wr_pulse;
            r_timeout   <= w_timeout;
            r_perr      <= w_perr;
            // Registered from next state so it rises together with the pulse.
            r_rd_active <= (w_state_nxt == ACT_RD);
            if (w_rd_pulse || w_wr_pulse) r_addr  <= w_addr_s;
            if (w_wr_pulse)               r_wdata <= w_data_s;
        end
    end

    assign io_read_pulse        = r_rd_pulse;
    assign io_write_pulse       = r_wr_pulse;
    assign timeout_pulse        = r_timeout;
    assign protocol_error_pulse = r_perr;
    assign io_read_active       = r_rd_active;
    assign io_address           = r_addr;
    assign io_write_data        = r_wdata;

endmodule

// File: tb/tb_z80_io_frontend.sv
// Directed bench for z80_io_frontend with default parameters
// (2 sync stages, 3 filter cycles, timeout 1023). Inputs change on the
// falling edge; outputs are sampled 1 time unit after each rising edge.
// Edge n counts rising edges after the stimulus change, edge 1 being the
// first edge that samples the new raw inputs.
module tb_z80_io_frontend;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       wr_b = 1'b1;
    logic       rd_b = 1'b1;
    logic       ioreq_b = 1'b1;
    logic       m1 = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;

    logic       io_write_pulse, io_read_pulse, io_read_active;
    logic       timeout_pulse, protocol_error_pulse;
    logic [7:0] io_address, io_write_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_io_frontend dut (
        .clk                  (clk),
        .reset_b              (reset_b),
        .z80_write_strobe_b   (wr_b),
        .z80_read_strobe_b    (rd_b),
        .z80_ioreq_b          (ioreq_b),
        .z80_m1               (m1),
        .z80_address_bus      (addr),
        .z80_data_bus_in      (din),
        .io_write_pulse       (io_write_pulse),
        .io_read_pulse        (io_read_pulse),
        .io_address           (io_address),
        .io_write_data        (io_write_data),
        .io_read_active       (io_read_active),
        .timeout_pulse        (timeout_pulse),
        .protocol_error_pulse (protocol_error_pulse)
    );

    // Return the bus to idle and let the DUT settle back to IDLE.
    task automatic release_bus();
        @(negedge clk);
        wr_b = 1'b1; rd_b = 1'b1; ioreq_b = 1'b1; m1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({io_write_pulse, io_read_pulse, io_read_active, timeout_pulse, protocol_error_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {io_write_pulse, io_read_pulse, io_read_active, timeout_pulse, protocol_error_pulse});
        end
        checks++;
        if ({io_address, io_write_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_latches: got %h want 0000", {io_address, io_write_data});
        end
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({io_write_pulse, io_read_pulse, io_read_active, timeout_pulse, protocol_error_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL idle_flags: got %b want 00000",
                     {io_write_pulse, io_read_pulse, io_read_active, timeout_pulse, protocol_error_pulse});
        end
    endtask

    // T1: write 0x5A to 0x80, strobe held 20 clks.
    task automatic test_write();
        addr = 8'h80; din = 8'h5A; m1 = 1'b1; ioreq_b = 1'b0; wr_b = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_write_pulse !== (n == 5)) begin
                errors++;
                $display("FAIL t1_wr_pulse edge %0d: got %b want %b", n, io_write_pulse, (n == 5));
            end
            checks++;
            if (io_read_pulse !== 1'b0 || io_read_active !== 1'b0) begin
                errors++;
                $display("FAIL t1_no_read edge %0d: got %b%b want 00", n, io_read_pulse, io_read_active);
            end
        end
        checks++;
        if (io_address !== 8'h80) begin
            errors++;
            $display("FAIL t1_addr: got %h want 80", io_address);
        end
        checks++;
        if (io_write_data !== 8'h5A) begin
            errors++;
            $display("FAIL t1_data: got %h want 5a", io_write_data);
        end
        release_bus();
    endtask

    // T2: read 0x81, strobe 12 clks; active falls 2 clks after release.
    task automatic test_read();
        addr = 8'h81; din = 8'hEE; m1 = 1'b1; ioreq_b = 1'b0; rd_b = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_read_pulse !== (n == 5)) begin
                errors++;
                $display("FAIL t2_rd_pulse edge %0d: got %b want %b", n, io_read_pulse, (n == 5));
            end
            checks++;
            if (io_read_active !== (n >= 5 && n <= 14)) begin
                errors++;
                $display("FAIL t2_active edge %0d: got %b want %b", n, io_read_active, (n >= 5 && n <= 14));
            end
            checks++;
            if (io_write_pulse !== 1'b0) begin
                errors++;
                $display("FAIL t2_no_write edge %0d: got %b want 0", n, io_write_pulse);
            end
            if (n == 12) begin
                @(negedge clk);
                rd_b = 1'b1; ioreq_b = 1'b1;
            end
        end
        checks++;
        if (io_address !== 8'h81) begin
            errors++;
            $display("FAIL t2_addr: got %h want 81", io_address);
        end
        checks++;
        if (io_write_data !== 8'h5A) begin
            errors++;
            $display("FAIL t2_wdata_kept: got %h want 5a", io_write_data);
        end
        release_bus();
    endtask

    // T3: 2-clk write glitch, then a long INTACK-style cycle.
    task automatic test_glitch();
        addr = 8'h10; din = 8'h11; m1 = 1'b1; ioreq_b = 1'b0; wr_b = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_write_pulse !== 1'b0 || io_read_pulse !== 1'b0) begin
                errors++;
                $display("FAIL t3_glitch edge %0d: got %b%b want 00", n, io_write_pulse, io_read_pulse);
            end
            if (n == 2) begin
                @(negedge clk);
                wr_b = 1'b1; ioreq_b = 1'b1;
            end
        end
        release_bus();
        addr = 8'h20; din = 8'h22; m1 = 1'b0; ioreq_b = 1'b0; wr_b = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_write_pulse !== 1'b0 || io_read_pulse !== 1'b0) begin
                errors++;
                $display("FAIL t3_intack edge %0d: got %b%b want 00", n, io_write_pulse, io_read_pulse);
            end
        end
        checks++;
        if ({io_address, io_write_data} !== 16'h815A) begin
            errors++;
            $display("FAIL t3_latches: got %h want 815a", {io_address, io_write_data});
        end
        release_bus();
    endtask

    // T4: read held 1100 clks; timeout at edge 5+1023+1.
    task automatic test_timeout();
        int rd_cnt;
        int to_cnt;
        rd_cnt = 0; to_cnt = 0;
        addr = 8'h42; m1 = 1'b1; ioreq_b = 1'b0; rd_b = 1'b0;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk); #1;
            rd_cnt += int'(io_read_pulse);
            to_cnt += int'(timeout_pulse);
            checks++;
            if (timeout_pulse !== (n == 1029)) begin
                errors++;
                $display("FAIL t4_timeout edge %0d: got %b want %b", n, timeout_pulse, (n == 1029));
            end
            checks++;
            if (io_read_active !== (n >= 5 && n < 1029)) begin
                errors++;
                $display("FAIL t4_active edge %0d: got %b want %b", n, io_read_active, (n >= 5 && n < 1029));
            end
        end
        checks++;
        if (rd_cnt != 1 || to_cnt != 1) begin
            errors++;
            $display("FAIL t4_counts: got rd=%0d to=%0d want rd=1 to=1", rd_cnt, to_cnt);
        end
        @(negedge clk);
        rd_b = 1'b1; ioreq_b = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({io_read_pulse, io_write_pulse, timeout_pulse, io_read_active} !== 4'b0) begin
                errors++;
                $display("FAIL t4_after_release edge %0d: got %b want 0000", n,
                         {io_read_pulse, io_write_pulse, timeout_pulse, io_read_active});
            end
        end
        @(negedge clk);
        addr = 8'h43; ioreq_b = 1'b0; rd_b = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_read_pulse !== (n == 5)) begin
                errors++;
                $display("FAIL t4_fresh_pulse edge %0d: got %b want %b", n, io_read_pulse, (n == 5));
            end
        end
        checks++;
        if (io_address !== 8'h43) begin
            errors++;
            $display("FAIL t4_fresh_addr: got %h want 43", io_address);
        end
        release_bus();
    endtask

    // T5: read and write asserted together.
    task automatic test_protocol_error();
        addr = 8'h55; din = 8'h66; m1 = 1'b1; ioreq_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            checks++;
            if (protocol_error_pulse !== (n == 3)) begin
                errors++;
                $display("FAIL t5_perr edge %0d: got %b want %b", n, protocol_error_pulse, (n == 3));
            end
            checks++;
            if ({io_read_pulse, io_write_pulse, io_read_active} !== 3'b0) begin
                errors++;
                $display("FAIL t5_no_io edge %0d: got %b want 000", n,
                         {io_read_pulse, io_write_pulse, io_read_active});
            end
        end
        release_bus();
    endtask

    // T6: reset in the middle of an active write, strobe still held at release.
    task automatic test_reset_mid();
        addr = 8'h33; din = 8'hC3; m1 = 1'b1; ioreq_b = 1'b0; wr_b = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_write_pulse !== (n == 5)) begin
                errors++;
                $display("FAIL t6_first_pulse edge %0d: got %b want %b", n, io_write_pulse, (n == 5));
            end
        end
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        checks++;
        if ({io_address, io_write_data} !== 16'h0000) begin
            errors++;
            $display("FAIL t6_async_clear: got %h want 0000", {io_address, io_write_data});
        end
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            checks++;
            if (io_write_pulse !== (n == 5)) begin
                errors++;
                $display("FAIL t6_requal edge %0d: got %b want %b", n, io_write_pulse, (n == 5));
            end
        end
        checks++;
        if ({io_address, io_write_data} !== 16'h33C3) begin
            errors++;
            $display("FAIL t6_latches: got %h want 33c3", {io_address, io_write_data});
        end
        release_bus();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_glitch();
        test_timeout();
        test_protocol_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
